// File: rtl/divider_if.sv
// Handshake and operand/result bundle between the EX-stage issue logic and the divider.
interface divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             BUSY;
  logic             DONE;
  logic             DIV0;

  modport master (
    output start, is_signed, X, Y,
    input  Q, R, BUSY, DONE, DIV0
  );

  modport slave (
    input  start, is_signed, X, Y,
    output Q, R, BUSY, DONE, DIV0
  );
endinterface

// File: rtl/divider.sv
// Sequential restoring divider: signed/unsigned quotient and remainder in a fixed 33 cycles,
// with divide-by-zero flagged and the remainder taking the sign of the dividend.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, EXECUTE, FIXUP, FINISH} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic             div0_q;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;

  // The stored partial remainder never exceeds the divisor, so its 33rd bit is
  // always zero and only WIDTH bits are kept; the shifted value keeps the carry.
  always_comb begin
    p_shift = {p_q, dvd_q[WIDTH-1]};
    trial   = p_shift - {1'b0, dvs_q};
    x_mag   = (bus.is_signed && bus.X[WIDTH-1]) ? (~bus.X + WIDTH'(1)) : bus.X;
    y_mag   = (bus.is_signed && bus.Y[WIDTH-1]) ? (~bus.Y + WIDTH'(1)) : bus.Y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      x_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            neg_q_q <= bus.is_signed & (bus.X[WIDTH-1] ^ bus.Y[WIDTH-1]);
            neg_r_q <= bus.is_signed & bus.X[WIDTH-1];
            dvd_q   <= x_mag;
            dvs_q   <= y_mag;
            x_q     <= bus.X;
            zero_q  <= (bus.Y == '0);
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (!trial[WIDTH]) begin
            p_q   <= trial[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            p_q   <= p_shift[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIXUP;
          end
        end
        FIXUP: begin
          if (zero_q) begin
            quo_q <= '1;
            rem_q <= x_q;
          end else begin
            quo_q <= neg_q_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
            rem_q <= neg_r_q ? (~p_q + WIDTH'(1)) : p_q;
          end
          div0_q  <= zero_q;
          done_q  <= 1'b1;
          state_q <= FINISH;
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Q    = quo_q;
  assign bus.R    = rem_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.DIV0 = div0_q;

endmodule

// File: doc/divider.md
# divider

Sequential 32-bit integer divider for the EX-stage multi-cycle unit: the inverse-direction companion of the Booth multiplier. It accepts a dividend/divisor pair on a start pulse and produces a quotient and remainder after a fixed 33-cycle restoring-division sequence. Signed or unsigned operation is selected per operation, and divide-by-zero is flagged. The pipeline stalls on BUSY and retires on DONE.

## Interface
- WIDTH, 32, operand and result width. Only 32 is verified.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned. Captured with start.
- X  input  32  dividend. Captured with start.
- Y  input  32  divisor. Captured with start.
- Q  output  32  quotient. Registered, holds the last result.
- R  output  32  remainder. Registered, holds the last result.
- BUSY  output  1  high from the start-accept edge until DONE falls.
- DONE  output  1  one-cycle pulse when Q/R/DIV0 become valid.
- DIV0  output  1  Y was zero for the last operation. Registered with Q/R.

## Operation
- States:
  - IDLE: waits for start.
  - EXECUTE: 32 iterations.
  - FIXUP: sign and zero correction, result write.
  - FINISH: DONE cycle.
- IDLE, start=1:
  - Capture neg_q = is_signed & (X[31]^Y[31]) and neg_r = is_signed & X[31].
  - Load the magnitudes |X| and |Y|; unsigned operands are taken as-is.
  - Clear the 33-bit partial remainder P and the 6-bit count. Go to EXECUTE.
  - start=0 in IDLE: nothing changes.
- EXECUTE, each cycle:
  - Shift {P, dividend} left by 1.
  - Compute trial = P − {1'b0, divisor} (33-bit).
  - trial ≥ 0: P ← trial and set quotient LSB to 1. Otherwise keep P and set quotient LSB to 0.
  - Increment count. After the 32nd iteration (count==31 at the edge), go to FIXUP.
- FIXUP:
  - Q ← neg_q ? −quot : quot. R ← neg_r ? −P[31:0] : P[31:0].
  - Remainder sign follows the dividend (MIPS/C truncation semantics).
  - DIV0 ← (captured divisor == 0). Go to FINISH.
- Divide-by-zero:
  - The iterations still run, so latency is unchanged.
  - FIXUP forces Q = 0xFFFFFFFF and R = the original X (not the magnitude). DIV0 = 1.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF:
  - Produces Q = 0x80000000, R = 0, DIV0 = 0.
  - This falls out of magnitude arithmetic; no special casing is required beyond treating |0x80000000| as unsigned 0x80000000.
- FINISH: DONE=1 for this one cycle. Next edge: go to IDLE, DONE=0, BUSY=0.
- start asserted in EXECUTE, FIXUP or FINISH is ignored (not queued).
- Operand inputs X/Y/is_signed may change freely after the accept edge.

## Timing
- Reset values (after any rst edge, including mid-operation): state=IDLE, Q=0, R=0, DIV0=0, DONE=0, BUSY=0, count=0, P=0.
- rst overrides start on the same edge.
- Accept edge t0 (IDLE, start=1): BUSY=1 from t0.
- Edges t1..t32: EXECUTE iterations.
- Edge t33: FIXUP writes Q/R/DIV0 and enters FINISH. DONE=1 during cycle t33→t34.
- Edge t34: IDLE, BUSY=0. The earliest next accept is edge t35 (start held high from t34).
- Start-to-DONE latency is 33 cycles for every operand, including zero and overflow cases.
- Q/R/DIV0 change only at the FIXUP edge or on reset. They stay stable through FINISH and IDLE.

## Test plan
- Unsigned 100/7 (is_signed=0):
  - DONE exactly 33 cycles after the accept edge.
  - Q=14, R=2, DIV0=0. DONE high one cycle. BUSY falls one cycle after DONE rises.
- Signed −7/2 (X=0xFFFFFFF9, Y=2, is_signed=1): Q=0xFFFFFFFD, R=0xFFFFFFFF. Also 7/−2: Q=0xFFFFFFFD, R=1.
- Extremes:
  - Unsigned 0xFFFFFFFF/1: Q=0xFFFFFFFF, R=0.
  - Signed 0x80000000/0xFFFFFFFF: Q=0x80000000, R=0, DIV0=0.
  - Unsigned 5/9: Q=0, R=5.
- Divide-by-zero, X=0x12345678, Y=0 (both modes): Q=0xFFFFFFFF, R=0x12345678, DIV0=1, latency 33.
- Handshake:
  - start held high continuously with new operands pulsed mid-operation: those operands are ignored.
  - Results match the operands captured at t0. The back-to-back second accept occurs exactly at t35.
- Reset mid-operation: assert rst at iteration 10. Next cycle all outputs are 0 and state is IDLE. A fresh 100/7 then completes correctly in 33 cycles.
